pc_sequencer: RTL and testbench

Program-counter sequencer for the 32-bit MIPS datapath. It holds the fetch PC and produces PC+4. It takes redirect requests from the execute stage and applies them:
- branch target = base PC + sign-extended offset already shifted left by 2
- J-type jump and `jr` register jump

It drives the fetch stage, emits a one-cycle pipeline flush after every redirect, and halts with a sticky error on a misaligned jump target.

---
 rtl/mips_pkg.sv | 13 +
 rtl/pc_target_mux.sv | 50 +++++
 rtl/pc_sequencer.sv | 76 +++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: sequencer state encodings,
// the PC increment and the default reset vector.
package mips_pkg;

   localparam logic [1:0] ST_BOOT  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational next-PC generator: branch adder, J-type concatenation,
// jr alignment check and the redirect priority select.
module pc_target_mux
   import mips_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic        i_stall,
   input  logic        i_branchTaken,
   input  logic [31:0] i_branchOffsetShifted,
   input  logic        i_jump,
   input  logic [25:0] i_jumpIndex,
   input  logic        i_jumpReg,
   input  logic [31:0] i_jumpRegAddr,
   input  logic [31:0] i_redirBasePC,
   output logic [31:0] o_nextPc,
   output logic        o_redirect,
   output logic        o_misalign
);

   logic [31:0] w_branchTarget;
   logic [31:0] w_jumpTarget;

   assign w_branchTarget = i_redirBasePC + i_branchOffsetShifted;
   assign w_jumpTarget   = {i_redirBasePC[31:28], i_jumpIndex, 2'b00};

   // Redirects win over Stall because the redirecting instruction is older.
   always_comb begin
      o_nextPc   = i_pc + PC_INC;
      o_redirect = 1'b0;
      o_misalign = 1'b0;
      if (i_jumpReg) begin
         if (i_jumpRegAddr[1:0] != 2'b00) begin
            o_nextPc   = i_pc;
            o_misalign = 1'b1;
         end else begin
            o_nextPc   = i_jumpRegAddr;
            o_redirect = 1'b1;
         end
      end else if (i_jump) begin
         o_nextPc   = w_jumpTarget;
         o_redirect = 1'b1;
      end else if (i_branchTaken) begin
         o_nextPc   = w_branchTarget;
         o_redirect = 1'b1;
      end else if (i_stall) begin
         o_nextPc   = i_pc;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register and sequencing FSM; applies execute-stage redirects,
// flags a one-cycle flush after each, and halts on a misaligned jr target.
module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchOffsetShifted,
   input  logic        Jump,
   input  logic [25:0] JumpIndex,
   input  logic        JumpReg,
   input  logic [31:0] JumpRegAddr,
   input  logic [31:0] RedirBasePC,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        FetchValid,
   output logic        Flush,
   output logic        MisalignErr
);

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic        r_err;
   logic [31:0] w_nextPc;
   logic        w_redirect;
   logic        w_misalign;

   pc_target_mux u_mux (
      .i_pc                  (r_pc),
      .i_stall               (Stall),
      .i_branchTaken         (BranchTaken),
      .i_branchOffsetShifted (BranchOffsetShifted),
      .i_jump                (Jump),
      .i_jumpIndex           (JumpIndex),
      .i_jumpReg             (JumpReg),
      .i_jumpRegAddr         (JumpRegAddr),
      .i_redirBasePC         (RedirBasePC),
      .o_nextPc              (w_nextPc),
      .o_redirect            (w_redirect),
      .o_misalign            (w_misalign)
   );

   // BOOT and HALT ignore all redirect inputs; only RUN/FLUSH consult the mux.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state <= ST_BOOT;
         r_pc    <= RESET_PC;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_BOOT: r_state <= ST_RUN;
            ST_RUN, ST_FLUSH: begin
               if (w_misalign) begin
                  r_err   <= 1'b1;
                  r_state <= ST_HALT;
               end else begin
                  r_pc    <= w_nextPc;
                  r_state <= w_redirect ? ST_FLUSH : ST_RUN;
               end
            end
            default: r_state <= ST_HALT;
         endcase
      end
   end

   assign PC          = r_pc;
   assign PCPlus4     = r_pc + PC_INC;
   assign FetchValid  = (r_state == ST_RUN) || (r_state == ST_FLUSH);
   assign Flush       = (r_state == ST_FLUSH);
   assign MisalignErr = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with RESET_PC = 0x0040_0000.
module tb_pc_sequencer;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        Stall = 1'b0;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchOffsetShifted = 32'h0;
   logic        Jump = 1'b0;
   logic [25:0] JumpIndex = 26'h0;
   logic        JumpReg = 1'b0;
   logic [31:0] JumpRegAddr = 32'h0;
   logic [31:0] RedirBasePC = 32'h0;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        FetchValid;
   logic        Flush;
   logic        MisalignErr;

   int total = 0;
   int bad = 0;

   pc_sequencer #(.RESET_PC(32'h0040_0000)) dut (
      .Clk                 (Clk),
      .Rst                 (Rst),
      .Stall               (Stall),
      .BranchTaken         (BranchTaken),
      .BranchOffsetShifted (BranchOffsetShifted),
      .Jump                (Jump),
      .JumpIndex           (JumpIndex),
      .JumpReg             (JumpReg),
      .JumpRegAddr         (JumpRegAddr),
      .RedirBasePC         (RedirBasePC),
      .PC                  (PC),
      .PCPlus4             (PCPlus4),
      .FetchValid          (FetchValid),
      .Flush               (Flush),
      .MisalignErr         (MisalignErr)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic clearInputs();
      Stall       = 1'b0;
      BranchTaken = 1'b0;
      Jump        = 1'b0;
      JumpReg     = 1'b0;
   endtask

   task automatic test_reset();
      #2 Rst = 1'b1;
      #2;
      total++; if (PC !== 32'h0040_0000) begin bad++; $display("[TB] FAIL reset_pc: got %h want %h", PC, 32'h0040_0000); end
      total++; if (PCPlus4 !== 32'h0040_0004) begin bad++; $display("[TB] FAIL reset_pcplus4: got %h want %h", PCPlus4, 32'h0040_0004); end
      total++; if (FetchValid !== 1'b0 || Flush !== 1'b0 || MisalignErr !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags: got fv=%b fl=%b err=%b want 0 0 0", FetchValid, Flush, MisalignErr); end
      tick();
      tick();
      Rst = 1'b0;
      total++; if (FetchValid !== 1'b0) begin bad++; $display("[TB] FAIL boot_fetchvalid: got %b want 0", FetchValid); end
      tick();
      total++; if (FetchValid !== 1'b1 || PC !== 32'h0040_0000) begin bad++; $display("[TB] FAIL first_fetch: got fv=%b pc=%h want 1 00400000", FetchValid, PC); end
      tick();
      tick();
      total++; if (PC !== 32'h0040_0008) begin bad++; $display("[TB] FAIL run_advance: got %h want %h", PC, 32'h0040_0008); end
   endtask

   task automatic test_branch();
      RedirBasePC         = 32'h0040_0010;
      BranchOffsetShifted = 32'hFFFF_FFF0;
      BranchTaken         = 1'b1;
      Stall               = 1'b1;
      tick();
      clearInputs();
      total++; if (PC !== 32'h0040_0000 || Flush !== 1'b1) begin bad++; $display("[TB] FAIL branch_target: got pc=%h fl=%b want 00400000 1", PC, Flush); end
      tick();
      total++; if (PC !== 32'h0040_0004 || Flush !== 1'b0) begin bad++; $display("[TB] FAIL branch_after: got pc=%h fl=%b want 00400004 0", PC, Flush); end
   endtask

   task automatic test_stall();
      Stall = 1'b1;
      tick();
      total++; if (PC !== 32'h0040_0004 || FetchValid !== 1'b1) begin bad++; $display("[TB] FAIL stall_hold: got pc=%h fv=%b want 00400004 1", PC, FetchValid); end
      Stall = 1'b0;
      tick();
      total++; if (PC !== 32'h0040_0008) begin bad++; $display("[TB] FAIL stall_release: got %h want %h", PC, 32'h0040_0008); end
   endtask

   task automatic test_jump();
      RedirBasePC = 32'h9000_0000;
      JumpIndex   = 26'h0000_100;
      Jump        = 1'b1;
      tick();
      clearInputs();
      total++; if (PC !== 32'h9000_0400 || Flush !== 1'b1) begin bad++; $display("[TB] FAIL jump_target: got pc=%h fl=%b want 90000400 1", PC, Flush); end
      tick();
      total++; if (PC !== 32'h9000_0404 || Flush !== 1'b0) begin bad++; $display("[TB] FAIL jump_after: got pc=%h fl=%b want 90000404 0", PC, Flush); end
   endtask

   task automatic test_back_to_back();
      RedirBasePC         = 32'h0000_1000;
      BranchOffsetShifted = 32'h0000_0020;
      BranchTaken         = 1'b1;
      tick();
      clearInputs();
      total++; if (PC !== 32'h0000_1020 || Flush !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first: got pc=%h fl=%b want 00001020 1", PC, Flush); end
      RedirBasePC = 32'h2000_0000;
      JumpIndex   = 26'h0000_040;
      Jump        = 1'b1;
      BranchTaken = 1'b1;
      tick();
      clearInputs();
      total++; if (PC !== 32'h2000_0100 || Flush !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second: got pc=%h fl=%b want 20000100 1", PC, Flush); end
      JumpRegAddr = 32'h0000_3000;
      JumpReg     = 1'b1;
      Jump        = 1'b1;
      tick();
      clearInputs();
      total++; if (PC !== 32'h0000_3000 || Flush !== 1'b1) begin bad++; $display("[TB] FAIL jr_priority: got pc=%h fl=%b want 00003000 1", PC, Flush); end
      tick();
      total++; if (PC !== 32'h0000_3004 || Flush !== 1'b0) begin bad++; $display("[TB] FAIL b2b_end: got pc=%h fl=%b want 00003004 0", PC, Flush); end
   endtask

   task automatic test_wrap();
      JumpRegAddr = 32'hFFFF_FFFC;
      JumpReg     = 1'b1;
      tick();
      clearInputs();
      total++; if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0000_0000) begin bad++; $display("[TB] FAIL wrap_top: got pc=%h p4=%h want fffffffc 00000000", PC, PCPlus4); end
      tick();
      total++; if (PC !== 32'h0000_0000 || PCPlus4 !== 32'h0000_0004) begin bad++; $display("[TB] FAIL wrap_zero: got pc=%h p4=%h want 00000000 00000004", PC, PCPlus4); end
      tick();
   endtask

   task automatic test_misalign();
      JumpRegAddr = 32'h0000_1002;
      JumpReg     = 1'b1;
      tick();
      clearInputs();
      total++; if (PC !== 32'h0000_0004 || MisalignErr !== 1'b1 || FetchValid !== 1'b0 || Flush !== 1'b0) begin bad++; $display("[TB] FAIL misalign_halt: got pc=%h err=%b fv=%b fl=%b want 00000004 1 0 0", PC, MisalignErr, FetchValid, Flush); end
      RedirBasePC = 32'h9000_0000;
      JumpIndex   = 26'h0000_100;
      Jump        = 1'b1;
      BranchTaken = 1'b1;
      tick();
      tick();
      clearInputs();
      total++; if (PC !== 32'h0000_0004 || MisalignErr !== 1'b1 || FetchValid !== 1'b0) begin bad++; $display("[TB] FAIL halt_ignores: got pc=%h err=%b fv=%b want 00000004 1 0", PC, MisalignErr, FetchValid); end
      #2 Rst = 1'b1;
      #1;
      total++; if (PC !== 32'h0040_0000 || MisalignErr !== 1'b0 || FetchValid !== 1'b0) begin bad++; $display("[TB] FAIL halt_reset: got pc=%h err=%b fv=%b want 00400000 0 0", PC, MisalignErr, FetchValid); end
      tick();
      Rst = 1'b0;
      tick();
      total++; if (PC !== 32'h0040_0000 || FetchValid !== 1'b1) begin bad++; $display("[TB] FAIL restart: got pc=%h fv=%b want 00400000 1", PC, FetchValid); end
   endtask

   initial begin
      test_reset();
      test_branch();
      test_stall();
      test_jump();
      test_back_to_back();
      test_wrap();
      test_misalign();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
